// File: rtl/lsu_ctrl.sv
// Load/store sequencer: decodes CPU memory ops into bus lane patterns, runs a
// req/ack transfer with timeout and captures the byte-extended load result.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [2:0]  cpu_op,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_busy,
  output logic        cpu_done,
  output logic [31:0] cpu_rdata,
  output logic        cpu_err,
  output logic [1:0]  cpu_err_code,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] ext_din,
  output logic [3:0]  ext_be,
  output logic        ext_op,
  input  logic [31:0] ext_dout
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_EXT, S_DONE} state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic [7:0]  wait_cnt;
  logic        zext_r;
  logic        op_byte, op_half, op_store, op_zext, misalign;
  logic [3:0]  be_dec;
  logic [31:0] wdata_dec;

  always_comb begin
    op_byte   = (cpu_op == 3'd0) || (cpu_op == 3'd3) || (cpu_op == 3'd5);
    op_half   = (cpu_op == 3'd1) || (cpu_op == 3'd4) || (cpu_op == 3'd6);
    op_store  = (cpu_op >= 3'd5);
    op_zext   = (cpu_op == 3'd2) || (cpu_op == 3'd3) || (cpu_op == 3'd4);
    be_dec    = 4'b1111;
    wdata_dec = cpu_wdata;
    misalign  = |cpu_addr[1:0];
    if (op_byte) begin
      be_dec    = 4'b0001 << cpu_addr[1:0];
      wdata_dec = {4{cpu_wdata[7:0]}};
      misalign  = 1'b0;
    end else if (op_half) begin
      be_dec    = cpu_addr[1] ? 4'b1100 : 4'b0011;
      wdata_dec = {2{cpu_wdata[15:0]}};
      misalign  = cpu_addr[0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cpu_busy = (state != S_IDLE);
    cpu_done = 1'b0;
    cpu_err  = 1'b0;
    bus_req  = 1'b0;
    unique case (state)
      S_IDLE: if (cpu_req) state_nx = misalign ? S_DONE : S_REQ;
      S_REQ: begin
        bus_req = 1'b1;
        // an ack on the last permitted cycle takes priority over the timeout
        if (bus_ack)                    state_nx = bus_we ? S_DONE : S_EXT;
        else if (wait_cnt == LAST_WAIT) state_nx = S_DONE;
      end
      S_EXT: state_nx = S_DONE;
      S_DONE: begin
        cpu_done = 1'b1;
        cpu_err  = (cpu_err_code != 2'b00);
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt     <= '0;
      zext_r       <= 1'b0;
      cpu_err_code <= '0;
      cpu_rdata    <= '0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_be       <= '0;
      bus_wdata    <= '0;
      ext_din      <= '0;
      ext_be       <= '0;
      ext_op       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (cpu_req) begin
          bus_addr     <= {cpu_addr[31:2], 2'b00};
          bus_be       <= be_dec;
          bus_wdata    <= wdata_dec;
          bus_we       <= op_store;
          zext_r       <= op_zext;
          wait_cnt     <= '0;
          cpu_err_code <= misalign ? 2'b01 : 2'b00;
        end
        S_REQ: begin
          if (bus_ack) begin
            if (!bus_we) begin
              ext_din <= bus_rdata;
              ext_be  <= bus_be;
              ext_op  <= zext_r;
            end
          end else if (wait_cnt == LAST_WAIT) begin
            cpu_err_code <= 2'b10;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_EXT:   cpu_rdata <= ext_dout;
        default: ;
      endcase
    end
  end

endmodule
